// File: rtl/resync_event_fifo.sv
// Receive side of a two-phase toggle handshake: synchronise req_toggle, capture
// the stable data word on each toggle, acknowledge, and buffer in a FWFT FIFO.
module resync_event_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_MODE    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_toggle,
    input  logic [WIDTH-1:0]           req_data,
    output logic                       ack_toggle,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       overflow,
    input  logic                       clr_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ARM_W = $clog2(SYNC_STAGES+2);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

    typedef enum logic {ST_ARM, ST_RUN} state_t;

    state_t                 state_q;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   ack_q;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic sync_lvl, event_w, pop, room, push, consume, drop;

    always_comb begin
        sync_lvl = sync_q[SYNC_STAGES-1];
        event_w  = (state_q == ST_RUN) && (sync_lvl != prev_q);
        pop      = (cnt_q != '0) && out_ready;
        room     = (cnt_q != DEPTH_C) || pop;
        push     = event_w && room;
        // In backpressure mode an event that cannot be pushed stays pending.
        consume  = (ACK_MODE != 0) ? push : event_w;
        drop     = (ACK_MODE == 0) && event_w && !room;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARM;
            arm_cnt_q <= '0;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            ack_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_toggle};
            case (state_q)
                ST_ARM: begin
                    // Adopt the settled request level as baseline: no spurious event.
                    if (arm_cnt_q == ARM_LAST) begin
                        prev_q  <= sync_lvl;
                        ack_q   <= sync_lvl;
                        state_q <= ST_RUN;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + ARM_W'(1);
                    end
                end
                default: begin
                    if (consume) begin
                        prev_q <= sync_lvl;
                        ack_q  <= ~ack_q;
                    end
                end
            endcase
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
            if (drop)              ovf_q <= 1'b1;
            else if (clr_overflow) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_data;
    end

    assign ack_toggle = ack_q;
    assign out_valid  = (cnt_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign fill_level = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_resync_event_fifo.sv
// Directed bench: one backpressure instance and one drop-on-full instance share
// the request stimulus; a scoreboard checks every popped word.
module tb_resync_event_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [7:0] data = 8'h00;
    logic       rdy1 = 1'b0, rdy0 = 1'b0;
    logic       clr = 1'b0;

    logic       ack1, val1, ovf1, ack0, val0, ovf0;
    logic [7:0] data1, data0;
    logic [2:0] fill1, fill0;

    int n_assert = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int ack_base;
    logic ack_last = 1'b0;
    logic [7:0] exp1[$];
    logic [7:0] exp0[$];

    always #5 clk = ~clk;

    resync_event_fifo #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .ACK_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .req_toggle(req), .req_data(data), .ack_toggle(ack1),
        .out_valid(val1), .out_ready(rdy1), .out_data(data1), .fill_level(fill1),
        .overflow(ovf1), .clr_overflow(clr));

    resync_event_fifo #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .ACK_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .req_toggle(req), .req_data(data), .ack_toggle(ack0),
        .out_valid(val0), .out_ready(rdy0), .out_data(data0), .fill_level(fill0),
        .overflow(ovf0), .clr_overflow(clr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input bit to1, input bit to0);
        data = w;
        req  = ~req;
        if (to1) exp1.push_back(w);
        if (to0) exp0.push_back(w);
    endtask

    task automatic wait_ack1(input string tag);
        int n = 0;
        while (ack1 !== req && n < 30) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(ack1), 32'(req));
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (ack1 !== ack_last) begin
                        ack_cnt++;
                        ack_last = ack1;
                    end
                    if (val1 && rdy1) begin
                        if (exp1.size() == 0) chk("pop1_extra", 32'(val1), 32'd0);
                        else                  chk("pop1_data", 32'(data1), 32'(exp1.pop_front()));
                    end
                    if (val0 && rdy0) begin
                        if (exp0.size() == 0) chk("pop0_extra", 32'(val0), 32'd0);
                        else                  chk("pop0_data", 32'(data0), 32'(exp0.pop_front()));
                    end
                end
            end
        join_none

        // Reset state
        tick(3);
        chk("rst_ack", 32'(ack1), 32'd0);
        chk("rst_valid", 32'(val1), 32'd0);
        chk("rst_fill", 32'(fill1), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        rst = 1'b0;
        tick(5);
        chk("arm_ack", 32'(ack1), 32'd0);
        chk("arm_valid", 32'(val1), 32'd0);

        // Single word latency: toggle before edge k, ack/valid after edge k+2
        send(8'h90, 1, 1);
        tick(2);
        chk("lat_ack_early", 32'(ack1), 32'd0);
        chk("lat_valid_early", 32'(val1), 32'd0);
        tick(1);
        chk("lat_ack", 32'(ack1), 32'd1);
        chk("lat_valid", 32'(val1), 32'd1);
        chk("lat_data", 32'(data1), 32'h90);
        chk("lat_fill", 32'(fill1), 32'd1);
        rdy1 = 1'b1; rdy0 = 1'b1;
        tick(1);
        rdy1 = 1'b0; rdy0 = 1'b0;
        chk("lat_fill_pop", 32'(fill1), 32'd0);
        chk("lat_q_empty", 32'(exp1.size()), 32'd0);

        // Handshaked sender loop, consumer always ready
        rdy1 = 1'b1; rdy0 = 1'b1;
        ack_base = ack_cnt;
        for (int i = 1; i <= 6; i++) begin
            send(8'(i), 1, 1);
            wait_ack1("loop_ack");
        end
        tick(4);
        chk("loop_ack_count", 32'(ack_cnt - ack_base), 32'd6);
        chk("loop_q1_empty", 32'(exp1.size()), 32'd0);
        chk("loop_q0_empty", 32'(exp0.size()), 32'd0);
        chk("loop_fill", 32'(fill1), 32'd0);

        // Five words into a stalled consumer
        rdy1 = 1'b0; rdy0 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1, 1);
            tick(4);
        end
        send(8'h05, 1, 0);
        tick(4);
        chk("bp_fill", 32'(fill1), 32'd4);
        chk("bp_ack_held", 32'(ack1 != req), 32'd1);
        chk("bp_ovf", 32'(ovf1), 32'd0);
        chk("drop_fill", 32'(fill0), 32'd4);
        chk("drop_ack", 32'(ack0), 32'(req));
        chk("drop_ovf", 32'(ovf0), 32'd1);
        chk("drop_head", 32'(data0), 32'h01);
        rdy1 = 1'b1;
        tick(1);
        rdy1 = 1'b0;
        chk("bp_fill_pp", 32'(fill1), 32'd4);
        chk("bp_ack_flip", 32'(ack1), 32'(req));
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_clr", 32'(ovf0), 32'd0);
        rdy1 = 1'b1; rdy0 = 1'b1;
        tick(8);
        chk("bp_q1_empty", 32'(exp1.size()), 32'd0);
        chk("drop_q0_empty", 32'(exp0.size()), 32'd0);
        chk("bp_fill_drain", 32'(fill1), 32'd0);

        // Full FIFO, event lands on the same edge as a pop; order kept across wrap
        rdy1 = 1'b0; rdy0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + 8'(i), 1, 1);
            tick(4);
        end
        send(8'hA4, 1, 0);
        tick(2);
        rdy1 = 1'b1;
        tick(1);
        rdy1 = 1'b0;
        chk("wrap_fill", 32'(fill1), 32'd4);
        chk("wrap_ack", 32'(ack1), 32'(req));
        chk("wrap_ovf0", 32'(ovf0), 32'd1);
        rdy1 = 1'b1; rdy0 = 1'b1;
        tick(8);
        chk("wrap_q1_empty", 32'(exp1.size()), 32'd0);
        chk("wrap_q0_empty", 32'(exp0.size()), 32'd0);

        // Request held high through reset becomes the baseline
        rst = 1'b1;
        req = 1'b1;
        exp1.delete();
        exp0.delete();
        tick(2);
        rst = 1'b0;
        tick(6);
        chk("rearm_ack", 32'(ack1), 32'd1);
        chk("rearm_fill", 32'(fill1), 32'd0);
        chk("rearm_valid", 32'(val1), 32'd0);
        rdy1 = 1'b0; rdy0 = 1'b0;
        send(8'h5A, 1, 1);
        wait_ack1("rearm_word_ack");
        tick(1);
        chk("rearm_word_fill", 32'(fill1), 32'd1);
        rdy1 = 1'b1; rdy0 = 1'b1;
        tick(4);
        chk("rearm_q1_empty", 32'(exp1.size()), 32'd0);
        chk("rearm_fill_end", 32'(fill1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/resync_event_fifo.md
Name: resync_event_fifo

Overview:
- Receive side of a two-phase (toggle) handshake carrying WIDTH-bit words from an unrelated clock domain, e.g. MIDI bytes from the UART clock into the synth core clock.
- Synchronises the request toggle through SYNC_STAGES flops and captures the data word only once the toggle is seen.
- Returns an acknowledge toggle so the sender knows when it may change the data. Data is never sampled while it may be changing.
- Buffers captured words in a DEPTH-entry first-word-fall-through FIFO with a valid/ready output.

Parameters:
WIDTH, 8, data word width (>=1)
DEPTH, 4, FIFO entries; power of two, >=2
SYNC_STAGES, 2, synchroniser flops on req_toggle (>=2)
ACK_MODE, 1, 1 = backpressure (ack withheld while full); 0 = fire-and-forget (drop on full, ack anyway)

Ports:
clk  in  1  core clock; all logic on posedge
rst  in  1  asynchronous reset, active-high
req_toggle  in  1  asynchronous request; each level change = one new word
req_data  in  WIDTH  asynchronous data; held stable by sender from before req_toggle changes until ack_toggle equals req_toggle
ack_toggle  out  1  registered acknowledge; toggles once per captured (or dropped) word
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head word when out_valid & out_ready
out_data  out  WIDTH  FIFO head word; valid only while out_valid
fill_level  out  $clog2(DEPTH+1)  registered word count, 0..DEPTH
overflow  out  1  sticky; set when a word is dropped (ACK_MODE=0 only)
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert; release synchronous to clk in system): sync chain, prev, FIFO pointers, fill_level, overflow, ack_toggle = 0. out_valid = 0. out_data contents undefined. State = ARM.
- ARM state: counter runs SYNC_STAGES+1 cycles after reset release. The event detector is masked during ARM.
- ARM exit: prev <= sync[S-1]; ack_toggle <= sync[S-1]. The req_toggle level present at reset becomes the baseline, so no spurious event is generated. Next state RUN.
- RUN: event = sync[S-1] != prev.
- Latency: a req_toggle change settled before clk edge k reaches sync[S-1] at edge k+S-1. On edge k+S:
  - req_data is sampled into the FIFO, ack_toggle flips, prev updates.
  - out_valid rises after edge k+S when the FIFO was empty.
  - The same edge k+S is also the earliest point at which the sender sees ack_toggle change.
- Push allowed when fill_level<DEPTH, or when fill_level==DEPTH and a pop happens in the same cycle.
- ACK_MODE=1, push not allowed:
  - prev, ack_toggle and FIFO are unchanged; the event stays pending.
  - The sender is stalled by the missing ack, so no data is lost.
  - The push occurs on the first edge where push is allowed.
- ACK_MODE=0, push not allowed:
  - Word discarded; ack_toggle and prev update anyway.
  - overflow <= 1 on that edge.
- Pop: out_valid & out_ready. Read pointer advances and fill_level decrements.
- Simultaneous push and pop: fill_level unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. fill_level is a separate counter.
- out_data = mem[rd_ptr] combinationally from registered state, giving first-word-fall-through.
- overflow priority: clr_overflow and a new drop in the same cycle leave overflow = 1.
- Only one event can be outstanding, since the protocol allows at most one unacknowledged toggle. At most one push per cycle is therefore sufficient.
- Reset mid-transfer: all buffered words are lost and the block re-enters ARM. After ARM, ack_toggle equals the current request level, so a sender stalled mid-handshake completes without a duplicate word.

Test Plan:
- SYNC_STAGES=2, idle, req_data=0x90, toggle req 0->1 before edge 10 -> ack_toggle=1 and out_valid=1 after edge 12; out_data=0x90; fill_level=1; pop -> fill_level=0.
- Sender loop: 6 words 0x01..0x06, each sent on ack, out_ready=1 -> words out in order, no duplicates, ack toggles exactly 6 times.
- ACK_MODE=1, DEPTH=4, out_ready=0, send 5 words -> fill_level=4, ack_toggle stays != req_toggle for word 5. Assert out_ready one cycle -> 0x05 pushed the same edge as the pop, fill_level stays 4, ack flips.
- ACK_MODE=0, same stimulus -> word 5 dropped, ack flips, overflow=1, FIFO holds 0x01..0x04. clr_overflow -> overflow=0.
- Hold req_toggle=1 through reset and release -> no push, ack_toggle=1 after ARM. Next toggle 1->0 -> exactly one word.
- Full FIFO with pending event, out_ready=1 and event on the same edge -> fill_level=4, pointers wrap, head order preserved across wrap.
